// File: rtl/score_judge.sv
// ---------------------------------------------------------------------------
// score_judge
//
// Reaction-time judge. A start edge arms a round: after a pseudo-random delay
// the stimulus lamp lights and the player's reaction time (counted in timing
// ticks) is graded into a 2-bit score. Pressing before the lamp lights is a
// foul and not pressing in time is a timeout. Both of these score 0.
//
// Ports
//   clk     in   1  system clock, all logic on the rising edge
//   reset   in   1  synchronous, active-high reset
//   start   in   1  round request level; only its rising edge acts
//   button  in   1  player press level; only its rising edge acts
//   stim    out  1  stimulus lamp, high while the reaction window is open
//   score   out  2  0 = foul/timeout, 1 = ok, 2 = good, 3 = great
//   en      out  1  high while score holds a finished round's result
//   busy    out  1  high while a round is in progress (WAIT or ARMED)
// ---------------------------------------------------------------------------
module score_judge #(
  parameter int TICK_DIV    = 50000,
  parameter int DELAY_TICKS = 500,
  parameter int GREAT_TICKS = 200,
  parameter int GOOD_TICKS  = 400,
  parameter int OK_TICKS    = 700
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       button,
  output logic       stim,
  output logic [1:0] score,
  output logic       en,
  output logic       busy
);

  // The tick counters must hold the longest delay (fixed part plus the
  // largest LFSR value, 15) as well as the timeout limit without wrapping.
  localparam int MAX_TICKS = ((DELAY_TICKS + 15) > OK_TICKS) ? (DELAY_TICKS + 15) : OK_TICKS;
  localparam int EW        = $clog2(MAX_TICKS + 1);
  localparam int DW        = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ARMED,
    ST_DONE
  } state_t;

  state_t          r_state;
  logic            r_startQ;
  logic            r_buttonQ;
  logic [3:0]      r_lfsr;
  logic [DW-1:0]   r_div;
  logic [EW-1:0]   r_elapsed;
  logic [EW-1:0]   r_target;
  logic            r_stim;
  logic [1:0]      r_score;
  logic            r_en;
  logic            r_busy;

  logic            w_startEdge;
  logic            w_btnEdge;
  logic            w_tick;
  logic [EW-1:0]   w_elapsedNext;
  logic [1:0]      w_pressScore;

  // Rising edges are formed from the live input and last cycle's registered
  // copy, so a result can land on the very edge that first sees the press.
  // A button held through reset or idle never produces an edge later on.
  assign w_startEdge = start & ~r_startQ;
  assign w_btnEdge   = button & ~r_buttonQ;

  // The prescaler counts 0..TICK_DIV-1. The tick fires on the last count, so
  // after a state entry (count cleared) the first tick arrives on the
  // TICK_DIV-th edge spent in that state.
  assign w_tick = (r_div == DW'(TICK_DIV - 1));

  assign w_elapsedNext = r_elapsed + EW'(1);

  // A press is graded on the elapsed count as it stood before any tick in the
  // same cycle. A press that coincides with the tick that would reach the
  // timeout therefore still sees OK_TICKS-1 and scores 1.
  always_comb begin
    w_pressScore = 2'd1;
    if (r_elapsed < EW'(GREAT_TICKS)) begin
      w_pressScore = 2'd3;
    end else if (r_elapsed < EW'(GOOD_TICKS)) begin
      w_pressScore = 2'd2;
    end
  end

  // Main sequencer. All outputs are registered here together with the state.
  // The LFSR (x^4 + x^3 + 1, seed 0001) free-runs in every state, so the
  // round delay depends on how many cycles passed since reset before start.
  // Every state entry clears the prescaler so tick timing is measured from
  // the moment the state was entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_startQ  <= 1'b0;
      r_buttonQ <= 1'b0;
      r_lfsr    <= 4'b0001;
      r_div     <= '0;
      r_elapsed <= '0;
      r_target  <= '0;
      r_stim    <= 1'b0;
      r_score   <= 2'd0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_startQ  <= start;
      r_buttonQ <= button;
      r_lfsr    <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
      r_div     <= w_tick ? '0 : (r_div + DW'(1));

      case (r_state)
        // Idle and done both wait for a new round; done keeps the previous
        // result on display until then. Button edges are ignored here.
        ST_IDLE, ST_DONE: begin
          if (w_startEdge) begin
            r_state   <= ST_WAIT;
            r_target  <= EW'(DELAY_TICKS) + EW'(r_lfsr);
            r_elapsed <= '0;
            r_div     <= '0;
            r_en      <= 1'b0;
            r_score   <= 2'd0;
            r_busy    <= 1'b1;
          end
        end

        // Pre-stimulus delay. A press here is a foul. The lamp lights on the
        // tick that brings the elapsed count up to the target.
        ST_WAIT: begin
          if (w_btnEdge) begin
            r_state <= ST_DONE;
            r_div   <= '0;
            r_score <= 2'd0;
            r_en    <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            if (w_elapsedNext == r_target) begin
              r_state   <= ST_ARMED;
              r_elapsed <= '0;
              r_div     <= '0;
              r_stim    <= 1'b1;
            end else begin
              r_elapsed <= w_elapsedNext;
            end
          end
        end

        // Reaction window. The press takes priority over the timeout tick.
        ST_ARMED: begin
          if (w_btnEdge) begin
            r_state <= ST_DONE;
            r_div   <= '0;
            r_score <= w_pressScore;
            r_en    <= 1'b1;
            r_stim  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            if (w_elapsedNext == EW'(OK_TICKS)) begin
              r_state   <= ST_DONE;
              r_div     <= '0;
              r_elapsed <= w_elapsedNext;
              r_score   <= 2'd0;
              r_en      <= 1'b1;
              r_stim    <= 1'b0;
              r_busy    <= 1'b0;
            end else begin
              r_elapsed <= w_elapsedNext;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_stim  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign stim  = r_stim;
  assign score = r_score;
  assign en    = r_en;
  assign busy  = r_busy;

endmodule

// File: tb/tb_score_judge.sv
// ---------------------------------------------------------------------------
// tb_score_judge
//
// Self-checking bench for score_judge with small timing parameters. A
// cycle-count reference model predicts every output on every cycle, and the
// directed rounds add hand-computed literal expectations on top.
// ---------------------------------------------------------------------------
module tb_score_judge;

  localparam int TD = 4;
  localparam int DL = 2;
  localparam int GR = 2;
  localparam int GD = 4;
  localparam int OK = 6;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       start  = 1'b0;
  logic       button = 1'b0;
  logic       stim;
  logic [1:0] score;
  logic       en;
  logic       busy;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  score_judge #(
    .TICK_DIV   (TD),
    .DELAY_TICKS(DL),
    .GREAT_TICKS(GR),
    .GOOD_TICKS (GD),
    .OK_TICKS   (OK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .button(button),
    .stim  (stim),
    .score (score),
    .en    (en),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference model. It counts clock edges since each state entry instead of
  // modelling a prescaler: the lamp lights target*TD edges after the round
  // starts, the window times out OK*TD edges after it lights, and a press on
  // edge n of the window has seen (n-1)/TD whole ticks.
  typedef enum int {M_IDLE, M_WAIT, M_ARMED, M_DONE} mphase_t;
  mphase_t    mPhase = M_IDLE;
  int         mN = 0;
  int         mTarget = 0;
  int         mE = 0;
  logic [3:0] mLfsr = 4'b0001;
  bit         mPrevS = 1'b0;
  bit         mPrevB = 1'b0;
  bit         mSEdge;
  bit         mBEdge;
  logic       expStim = 1'b0;
  logic       expEn = 1'b0;
  logic       expBusy = 1'b0;
  int         expScore = 0;

  always @(posedge clk) begin
    if (reset) begin
      mPhase = M_IDLE; mN = 0; mTarget = 0; mLfsr = 4'b0001;
      mPrevS = 1'b0; mPrevB = 1'b0;
      expStim = 1'b0; expEn = 1'b0; expBusy = 1'b0; expScore = 0;
    end else begin
      mSEdge = start && !mPrevS;
      mBEdge = button && !mPrevB;
      mN = mN + 1;
      case (mPhase)
        M_IDLE, M_DONE: begin
          if (mSEdge) begin
            mTarget = DL + int'(mLfsr);
            mPhase = M_WAIT; mN = 0;
            expEn = 1'b0; expScore = 0; expBusy = 1'b1;
          end
        end
        M_WAIT: begin
          if (mBEdge) begin
            mPhase = M_DONE; expScore = 0; expEn = 1'b1; expBusy = 1'b0;
          end else if (mN == mTarget * TD) begin
            mPhase = M_ARMED; mN = 0; expStim = 1'b1;
          end
        end
        M_ARMED: begin
          if (mBEdge) begin
            mE = (mN - 1) / TD;
            expScore = (mE < GR) ? 3 : ((mE < GD) ? 2 : 1);
            mPhase = M_DONE; expEn = 1'b1; expStim = 1'b0; expBusy = 1'b0;
          end else if (mN == OK * TD) begin
            mPhase = M_DONE; expScore = 0; expEn = 1'b1; expStim = 1'b0; expBusy = 1'b0;
          end
        end
        default: mPhase = M_IDLE;
      endcase
      mPrevS = start;
      mPrevB = button;
      mLfsr = {mLfsr[2:0], mLfsr[3] ^ mLfsr[2]};
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_stim", int'(stim), int'(expStim));
      checkOutput("model_score", int'(score), expScore);
      checkOutput("model_en", int'(en), int'(expEn));
      checkOutput("model_busy", int'(busy), int'(expBusy));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic b, input int n);
    start  = s;
    button = b;
    cyc(n);
  endtask

  task automatic waitStim(input string tag);
    int k = 0;
    while (!stim && k < 100) begin
      cyc(1);
      k++;
    end
    checkOutput({tag, "_stimSeen"}, int'(stim), 1);
  endtask

  // Round started on the first edge after reset: the LFSR still holds its
  // seed 1, so the target is 2+1 = 3 ticks and the lamp lights 12 edges on.
  task automatic firstRound(input string tag);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput({tag, "_busy"}, int'(busy), 1);
    applyStimulus(1'b0, 1'b0, 11);
    checkOutput({tag, "_stimLow"}, int'(stim), 0);
    cyc(1);
    checkOutput({tag, "_stimHigh"}, int'(stim), 1);
  endtask

  // Starts a round and presses so the press is sampled on edge pressN of the
  // reaction window.
  task automatic armedRound(input int pressN, input int want, input string tag);
    applyStimulus(1'b1, 1'b0, 1);
    start = 1'b0;
    waitStim(tag);
    cyc(pressN - 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput({tag, "_score"}, int'(score), want);
    checkOutput({tag, "_en"}, int'(en), 1);
    checkOutput({tag, "_stim"}, int'(stim), 0);
    applyStimulus(1'b0, 1'b0, 1);
  endtask

  initial begin
    int cnt;
    // Power-up reset.
    reset = 1'b1;
    cyc(2);
    checking = 1'b1;
    checkOutput("rst_stim", int'(stim), 0);
    checkOutput("rst_score", int'(score), 0);
    checkOutput("rst_en", int'(en), 0);
    checkOutput("rst_busy", int'(busy), 0);

    // Press one edge after the lamp lights -> great.
    firstRound("r1");
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("r1_score", int'(score), 3);
    checkOutput("r1_en", int'(en), 1);
    checkOutput("r1_stim", int'(stim), 0);
    checkOutput("r1_busy", int'(busy), 0);
    applyStimulus(1'b0, 1'b0, 1);

    // Grading boundaries: edge n sees e = (n-1)/4 ticks.
    armedRound(13, 2, "e3");
    armedRound(21, 1, "e5");
    armedRound(5, 3, "e1");
    armedRound(9, 2, "e2");
    armedRound(16, 2, "e3late");
    armedRound(17, 1, "e4");
    armedRound(24, 1, "tickTie");

    // No press: lamp stays lit for exactly 24 cycles, then a timeout.
    applyStimulus(1'b1, 1'b0, 1);
    start = 1'b0;
    waitStim("to");
    cnt = 0;
    while (stim && cnt < 100) begin
      cnt++;
      cyc(1);
    end
    checkOutput("to_stimCycles", cnt, 24);
    checkOutput("to_score", int'(score), 0);
    checkOutput("to_en", int'(en), 1);

    // Foul during the delay, then a fresh start drops en.
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("foul_stim", int'(stim), 0);
    checkOutput("foul_score", int'(score), 0);
    checkOutput("foul_en", int'(en), 1);
    checkOutput("foul_busy", int'(busy), 0);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("restart_en", int'(en), 0);
    checkOutput("restart_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b0, 100);

    // Reset while the lamp is lit, then the delay repeats the first round's.
    reset = 1'b1;
    cyc(2);
    firstRound("r2");
    cyc(2);
    reset = 1'b1;
    cyc(1);
    checkOutput("armRst_stim", int'(stim), 0);
    checkOutput("armRst_en", int'(en), 0);
    checkOutput("armRst_busy", int'(busy), 0);
    checkOutput("armRst_score", int'(score), 0);
    firstRound("r3");
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("r3_score", int'(score), 3);
    applyStimulus(1'b0, 1'b0, 1);

    // Button held from idle: no result until released and pressed again;
    // start edges inside the window change nothing.
    reset  = 1'b1;
    button = 1'b1;
    cyc(2);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1);
    start = 1'b0;
    waitStim("hold");
    cyc(5);
    checkOutput("hold_en", int'(en), 0);
    checkOutput("hold_busy", int'(busy), 1);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("hold_stillArmed", int'(stim), 1);
    checkOutput("hold_stillNoResult", int'(en), 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("hold_score", int'(score), 2);
    checkOutput("hold_en2", int'(en), 1);
    checkOutput("hold_stim", int'(stim), 0);
    applyStimulus(1'b0, 1'b0, 3);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (bad=%0d)", bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
